// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle controller and the datapath.
// mem_ready exists only when MC_CTRL_MEMWAIT_EN is defined.
interface mc_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             zero;
`ifdef MC_CTRL_MEMWAIT_EN
  logic             mem_ready;
`endif
  logic             pc_wr;
  logic             ir_wr;
  logic [1:0]       npc_op;
  logic [1:0]       extop;
  logic             alusrc;
  logic [1:0]       aluop;
  logic [1:0]       regdst;
  logic [1:0]       memtoreg;
  logic             reg_wr;
  logic             mem_wr;
  logic             illegal;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_cnt;

  // Controller side
  modport master (
    input  op, funct, zero,
`ifdef MC_CTRL_MEMWAIT_EN
    input  mem_ready,
`endif
    output pc_wr, ir_wr, npc_op, extop, alusrc, aluop, regdst, memtoreg,
    output reg_wr, mem_wr, illegal, state, instr_cnt
  );

  // Datapath side
  modport slave (
    output op, funct, zero,
`ifdef MC_CTRL_MEMWAIT_EN
    output mem_ready,
`endif
    input  pc_wr, ir_wr, npc_op, extop, alusrc, aluop, regdst, memtoreg,
    input  reg_wr, mem_wr, illegal, state, instr_cnt
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset main controller: FETCH/DECODE/EXE/MEM/WB sequencing and datapath selects.
// Latency: j/jal/jr 2, beq 3, alu/lui/sw 4, lw 5 cycles; outputs are combinational from state/op/funct.
// Backpressure: with MC_CTRL_MEMWAIT_EN, mem_ready low stalls FETCH and MEM; otherwise never stalls.
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic     clk,
  input  logic     reset,
  mc_ctrl_if.master bus
);

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXE    = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  state_t           st, st_nxt;
  logic [CNT_W-1:0] cnt;
  logic             done;
  logic             mem_rdy;

  logic is_addu, is_subu, is_jr, is_ori, is_lw, is_sw, is_beq, is_lui, is_j, is_jal;
  logic is_ralu, legal;
  logic [1:0] ext_v, aluop_v;
  logic       alusrc_v;

  logic       pc_wr, ir_wr, reg_wr, mem_wr, illegal, alusrc;
  logic [1:0] npc_op, extop, aluop, regdst, memtoreg;

`ifdef MC_CTRL_MEMWAIT_EN
  assign mem_rdy = bus.mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  assign is_addu = (bus.op == OP_R) && (bus.funct == FN_ADDU);
  assign is_subu = (bus.op == OP_R) && (bus.funct == FN_SUBU);
  assign is_jr   = (bus.op == OP_R) && (bus.funct == FN_JR);
  assign is_ori  = (bus.op == OP_ORI);
  assign is_lw   = (bus.op == OP_LW);
  assign is_sw   = (bus.op == OP_SW);
  assign is_beq  = (bus.op == OP_BEQ);
  assign is_lui  = (bus.op == OP_LUI);
  assign is_j    = (bus.op == OP_J);
  assign is_jal  = (bus.op == OP_JAL);
  assign is_ralu = is_addu | is_subu;
  assign legal   = is_ralu | is_jr | is_ori | is_lw | is_sw | is_beq | is_lui | is_j | is_jal;

  // Depends on op alone so the EXT output cannot glitch between DECODE and WB.
  assign ext_v = is_lui ? 2'b10 : ((is_lw | is_sw | is_beq) ? 2'b01 : 2'b00);

  always_comb begin
    aluop_v  = 2'b00;
    alusrc_v = 1'b0;
    if (is_subu || is_beq) aluop_v = 2'b01;
    if (is_ori || is_lui) begin
      aluop_v  = 2'b10;
      alusrc_v = 1'b1;
    end
    if (is_lw || is_sw) alusrc_v = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st  <= FETCH;
      cnt <= '0;
    end else begin
      st <= st_nxt;
      if (done) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    st_nxt   = FETCH;
    done     = 1'b0;
    pc_wr    = 1'b0;
    ir_wr    = 1'b0;
    reg_wr   = 1'b0;
    mem_wr   = 1'b0;
    illegal  = 1'b0;
    alusrc   = 1'b0;
    npc_op   = 2'b00;
    extop    = 2'b00;
    aluop    = 2'b00;
    regdst   = 2'b00;
    memtoreg = 2'b00;
    case (st)
      FETCH: begin
        ir_wr  = mem_rdy;
        pc_wr  = mem_rdy;
        st_nxt = mem_rdy ? DECODE : FETCH;
      end
      DECODE: begin
        extop = ext_v;
        if (is_j || is_jal) begin
          pc_wr  = 1'b1;
          npc_op = 2'b10;
          done   = 1'b1;
          if (is_jal) begin
            reg_wr   = 1'b1;
            regdst   = 2'b10;
            memtoreg = 2'b10;
          end
        end else if (is_jr) begin
          pc_wr  = 1'b1;
          npc_op = 2'b11;
          done   = 1'b1;
        end else if (!legal) begin
          illegal = 1'b1;
        end else begin
          st_nxt = EXE;
        end
      end
      EXE: begin
        extop  = ext_v;
        aluop  = aluop_v;
        alusrc = alusrc_v;
        if (is_beq) begin
          npc_op = 2'b01;
          pc_wr  = bus.zero;
          done   = 1'b1;
        end else if (is_lw || is_sw) begin
          st_nxt = MEM;
        end else if (is_ralu || is_ori || is_lui) begin
          st_nxt = WB;
        end
      end
      MEM: begin
        extop  = ext_v;
        aluop  = aluop_v;
        alusrc = alusrc_v;
        if (is_sw) begin
          mem_wr = 1'b1;
          done   = mem_rdy;
          st_nxt = mem_rdy ? FETCH : MEM;
        end else if (is_lw) begin
          st_nxt = mem_rdy ? WB : MEM;
        end
      end
      WB: begin
        extop    = ext_v;
        aluop    = aluop_v;
        alusrc   = alusrc_v;
        reg_wr   = is_ralu | is_ori | is_lui | is_lw;
        regdst   = is_ralu ? 2'b01 : 2'b00;
        memtoreg = is_lw ? 2'b01 : 2'b00;
        done     = reg_wr;
      end
      default: st_nxt = FETCH;
    endcase
    // Reset abandons any in-flight instruction: nothing may be written.
    if (!reset) begin
      pc_wr    = 1'b0;
      ir_wr    = 1'b0;
      reg_wr   = 1'b0;
      mem_wr   = 1'b0;
      illegal  = 1'b0;
      alusrc   = 1'b0;
      npc_op   = 2'b00;
      extop    = 2'b00;
      aluop    = 2'b00;
      regdst   = 2'b00;
      memtoreg = 2'b00;
    end
  end

  assign bus.pc_wr     = pc_wr;
  assign bus.ir_wr     = ir_wr;
  assign bus.npc_op    = npc_op;
  assign bus.extop     = extop;
  assign bus.alusrc    = alusrc;
  assign bus.aluop     = aluop;
  assign bus.regdst    = regdst;
  assign bus.memtoreg  = memtoreg;
  assign bus.reg_wr    = reg_wr;
  assign bus.mem_wr    = mem_wr;
  assign bus.illegal   = illegal;
  assign bus.state     = st;
  assign bus.instr_cnt = cnt;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized bench for mc_ctrl: per-cycle control words against an instruction-class model.
// Covers MC_CTRL_MEMWAIT_EN stalls when that macro is defined.
module tb_mc_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mc_ctrl_if #(.CNT_W(32)) bus ();
  mc_ctrl #(.CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  int          n_run = 0;
  int          n_fail = 0;
  logic [31:0] cnt_exp = '0;

  typedef struct packed {
    logic       pc_wr;
    logic       ir_wr;
    logic [1:0] npc_op;
    logic [1:0] extop;
    logic       alusrc;
    logic [1:0] aluop;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       reg_wr;
    logic       mem_wr;
    logic       illegal;
    logic [2:0] state;
  } ctl_t;

  localparam int K_ADDU = 0, K_SUBU = 1, K_JR = 2, K_ORI = 3, K_LW = 4, K_SW = 5;
  localparam int K_BEQ = 6, K_LUI = 7, K_J = 8, K_JAL = 9, K_BAD = 10;
  localparam int P_F = 0, P_D = 1, P_E = 2, P_M = 3, P_W = 4;

  function automatic int classify(input logic [5:0] op, input logic [5:0] f);
    if (op == 6'b000000) begin
      case (f)
        6'b100001: return K_ADDU;
        6'b100011: return K_SUBU;
        6'b001000: return K_JR;
        default:   return K_BAD;
      endcase
    end
    case (op)
      6'b001101: return K_ORI;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100: return K_BEQ;
      6'b001111: return K_LUI;
      6'b000010: return K_J;
      6'b000011: return K_JAL;
      default:   return K_BAD;
    endcase
  endfunction

  function automatic ctl_t observe();
    ctl_t o;
    o.pc_wr = bus.pc_wr;   o.ir_wr = bus.ir_wr;   o.npc_op = bus.npc_op;
    o.extop = bus.extop;   o.alusrc = bus.alusrc; o.aluop = bus.aluop;
    o.regdst = bus.regdst; o.memtoreg = bus.memtoreg;
    o.reg_wr = bus.reg_wr; o.mem_wr = bus.mem_wr; o.illegal = bus.illegal;
    o.state = bus.state;
    return o;
  endfunction

  // Expected control word and care mask for one cycle of an instruction of class k in phase ph.
  task automatic expect_word(input int k, input logic z, input int ph, input logic rdy,
                             output ctl_t e, output ctl_t c);
    logic ext_sp;
    e = '0;
    c = '0;
    c.pc_wr = 1'b1; c.ir_wr = 1'b1; c.reg_wr = 1'b1; c.mem_wr = 1'b1; c.illegal = 1'b1;
    c.state = 3'b111;
    e.state = 3'(ph);
    ext_sp = (k == K_ORI) || (k == K_LUI) || (k == K_LW) || (k == K_SW) || (k == K_BEQ);
    if (ph != P_F && ext_sp) begin
      c.extop = 2'b11;
      e.extop = (k == K_LUI) ? 2'b10 : ((k == K_ORI) ? 2'b00 : 2'b01);
    end
    if (ph == P_F) begin
      e.ir_wr = rdy; e.pc_wr = rdy;
      c.npc_op = 2'b11; c.extop = 2'b11;
    end else if (ph == P_D) begin
      if (k == K_J || k == K_JAL || k == K_JR) begin
        e.pc_wr = 1'b1; c.npc_op = 2'b11;
        e.npc_op = (k == K_JR) ? 2'b11 : 2'b10;
      end
      if (k == K_JAL) begin
        e.reg_wr = 1'b1; e.regdst = 2'b10; e.memtoreg = 2'b10;
        c.regdst = 2'b11; c.memtoreg = 2'b11;
      end
      if (k == K_BAD) e.illegal = 1'b1;
    end else begin
      c.alusrc = 1'b1; c.aluop = 2'b11;
      case (k)
        K_SUBU, K_BEQ: e.aluop = 2'b01;
        K_ORI, K_LUI:  begin e.aluop = 2'b10; e.alusrc = 1'b1; end
        K_LW, K_SW:    e.alusrc = 1'b1;
        default:       e.aluop = 2'b00;
      endcase
      if (ph == P_E && k == K_BEQ) begin
        c.npc_op = 2'b11; e.npc_op = 2'b01; e.pc_wr = z;
      end
      if (ph == P_M && k == K_SW) e.mem_wr = 1'b1;
      if (ph == P_W) begin
        e.reg_wr = 1'b1; c.regdst = 2'b11; c.memtoreg = 2'b11;
        e.regdst = (k == K_ADDU || k == K_SUBU) ? 2'b01 : 2'b00;
        e.memtoreg = (k == K_LW) ? 2'b01 : 2'b00;
      end
    end
  endtask

  // Drives one instruction through its whole life starting in FETCH, checking every cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input logic z,
                           input int fwait, input int mwait);
    int   k;
    int   ph_q[$];
    logic rdy_q[$];
    ctl_t e, c, o;
    k = classify(op, f);
    for (int i = 0; i <= fwait; i++) begin ph_q.push_back(P_F); rdy_q.push_back(i == fwait); end
    ph_q.push_back(P_D); rdy_q.push_back(1'b1);
    if (k != K_J && k != K_JAL && k != K_JR && k != K_BAD) begin
      ph_q.push_back(P_E); rdy_q.push_back(1'b1);
    end
    if (k == K_LW || k == K_SW)
      for (int i = 0; i <= mwait; i++) begin ph_q.push_back(P_M); rdy_q.push_back(i == mwait); end
    if (k == K_ADDU || k == K_SUBU || k == K_ORI || k == K_LUI || k == K_LW) begin
      ph_q.push_back(P_W); rdy_q.push_back(1'b1);
    end
    for (int s = 0; s < ph_q.size(); s++) begin
      @(negedge clk);
      bus.op = op; bus.funct = f; bus.zero = z;
`ifdef MC_CTRL_MEMWAIT_EN
      bus.mem_ready = rdy_q[s];
`endif
      #1;
      o = observe();
      expect_word(k, z, ph_q[s], rdy_q[s], e, c);
      n_run++;
      if ((19'(o) & 19'(c)) !== (19'(e) & 19'(c))) begin
        n_fail++;
        $display("FAIL ctl op=%b funct=%b step %0d: got %h expected %h (care %h)",
                 op, f, s, 19'(o), 19'(e), 19'(c));
      end
      if (s == 0) begin
        n_run++;
        if (bus.instr_cnt !== cnt_exp) begin
          n_fail++;
          $display("FAIL cnt_start op=%b: got %0d expected %0d", op, bus.instr_cnt, cnt_exp);
        end
      end
    end
    if (k != K_BAD) cnt_exp = cnt_exp + 1;
    @(posedge clk);
    #1;
    n_run++;
    if (bus.state !== 3'd0 || bus.instr_cnt !== cnt_exp) begin
      n_fail++;
      $display("FAIL retire op=%b funct=%b: got state %0d cnt %0d expected state 0 cnt %0d",
               op, f, bus.state, bus.instr_cnt, cnt_exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.op = 6'($urandom); bus.funct = 6'($urandom); bus.zero = 1'b1;
`ifdef MC_CTRL_MEMWAIT_EN
    bus.mem_ready = 1'b1;
`endif
    repeat (3) begin
      @(negedge clk);
      #1;
      n_run++;
      if (19'(observe()) !== 19'd0 || bus.instr_cnt !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_hold: got ctl %h cnt %0d expected ctl 0 cnt 0",
                 19'(observe()), bus.instr_cnt);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    cnt_exp = '0;
    #3;
    n_run++;
    if (bus.ir_wr !== 1'b1 || bus.pc_wr !== 1'b1 || bus.state !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_release: got ir_wr %b pc_wr %b state %0d expected 1 1 0",
               bus.ir_wr, bus.pc_wr, bus.state);
    end
  endtask

  task automatic test_alu_seq();
    run_instr(6'b001101, 6'($urandom), 1'b0, 0, 0);
    run_instr(6'b001111, 6'($urandom), 1'b0, 0, 0);
    run_instr(6'b100011, 6'($urandom), 1'b1, 0, 0);
    run_instr(6'b101011, 6'($urandom), 1'b0, 0, 0);
    run_instr(6'b000000, 6'b100001,    1'b0, 0, 0);
    run_instr(6'b000000, 6'b100011,    1'b1, 0, 0);
    n_run++;
    if (bus.instr_cnt !== 32'd6) begin
      n_fail++;
      $display("FAIL seq_count: got %0d expected 6", bus.instr_cnt);
    end
  endtask

  task automatic test_branch_jump();
    run_instr(6'b000100, 6'($urandom), 1'b1, 0, 0);
    run_instr(6'b000100, 6'($urandom), 1'b0, 0, 0);
    run_instr(6'b000011, 6'($urandom), 1'b0, 0, 0);
    run_instr(6'b000010, 6'($urandom), 1'b1, 0, 0);
    run_instr(6'b000000, 6'b001000,    1'b0, 0, 0);
  endtask

  task automatic test_illegal_and_reset_mid();
    run_instr(6'b111111, 6'($urandom), 1'b0, 0, 0);
    run_instr(6'b000000, 6'b000001,    1'b0, 0, 0);
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      bus.op = 6'b101011; bus.funct = 6'($urandom); bus.zero = 1'b0;
`ifdef MC_CTRL_MEMWAIT_EN
      bus.mem_ready = 1'b1;
`endif
      #1;
      n_run++;
      if (bus.state !== 3'(s)) begin
        n_fail++;
        $display("FAIL mid_path step %0d: got state %0d expected %0d", s, bus.state, s);
      end
    end
    reset = 1'b0;
    #1;
    n_run++;
    if (19'(observe()) >> 3 !== 19'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got ctl %h expected 0 (mem_wr %b)",
               19'(observe()), bus.mem_wr);
    end
    @(posedge clk);
    #1;
    n_run++;
    if (bus.state !== 3'd0 || bus.instr_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_reset_state: got state %0d cnt %0d expected 0 0",
               bus.state, bus.instr_cnt);
    end
    cnt_exp = '0;
    reset = 1'b1;
  endtask

  task automatic test_random();
    logic [5:0] op, f;
    int         pick;
    int         fw, mw;
    for (int n = 0; n < 60; n++) begin
      pick = $urandom_range(0, 11);
      f = 6'($urandom);
      case (pick)
        0: begin op = 6'b000000; f = 6'b100001; end
        1: begin op = 6'b000000; f = 6'b100011; end
        2: begin op = 6'b000000; f = 6'b001000; end
        3: op = 6'b001101;
        4: op = 6'b100011;
        5: op = 6'b101011;
        6: op = 6'b000100;
        7: op = 6'b001111;
        8: op = 6'b000010;
        9: op = 6'b000011;
        10: begin
          op = 6'b000000;
          for (int t = 0; t < 64 && classify(op, f) != K_BAD; t++) f = 6'($urandom);
        end
        default: begin
          op = 6'($urandom);
          for (int t = 0; t < 64 && (op == 6'd0 || classify(op, f) != K_BAD); t++) op = 6'($urandom);
        end
      endcase
`ifdef MC_CTRL_MEMWAIT_EN
      fw = $urandom_range(0, 2);
      mw = $urandom_range(0, 2);
`else
      fw = 0;
      mw = 0;
`endif
      run_instr(op, f, 1'($urandom), fw, mw);
    end
  endtask

`ifdef MC_CTRL_MEMWAIT_EN
  task automatic test_memwait();
    run_instr(6'b101011, 6'($urandom), 1'b0, 3, 2);
    run_instr(6'b100011, 6'($urandom), 1'b0, 1, 3);
  endtask
`endif

  initial begin
    test_reset();
    test_alu_seq();
    test_branch_jump();
    test_illegal_and_reset_mid();
    test_random();
`ifdef MC_CTRL_MEMWAIT_EN
    test_memwait();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
